// File: rtl/serial_bit_tx_if.sv
// Word handshake between a producer and the serial bit transmitter.
// The producer drives the master modport; the transmitter takes the slave modport.
interface serial_bit_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_bit_tx.sv
// Bit-serial transmitter: start bit, data LSB first, stop bit, each held CLKS_PER_BIT clocks.
// Define SERIAL_BIT_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_bit_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic           clock,
  input  logic           reset,
  serial_bit_tx_if.slave tx,
  output logic           tx_line,
  output logic           busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef SERIAL_BIT_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cyc_reg, cyc_next;
  logic [BW-1:0]         bit_reg, bit_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  line_reg, line_next;
  logic                  bit_done;
`ifdef SERIAL_BIT_TX_PARITY_EN
  logic                  par_reg, par_next;
`endif

  assign bit_done    = (cyc_reg == CYC_LAST);
  assign tx.tx_ready = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign tx_line     = line_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cyc_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      line_reg  <= 1'b1;
`ifdef SERIAL_BIT_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      line_reg  <= line_next;
`ifdef SERIAL_BIT_TX_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  // The line is registered, so line_next always carries the level of the state being entered.
  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    line_next  = line_reg;
`ifdef SERIAL_BIT_TX_PARITY_EN
    par_next   = par_reg;
`endif
    case (state_reg)
      IDLE: begin
        cyc_next  = '0;
        bit_next  = '0;
        line_next = 1'b1;
        if (tx.tx_valid) begin
          state_next = START;
          shift_next = tx.tx_data;
          line_next  = 1'b0;
`ifdef SERIAL_BIT_TX_PARITY_EN
          par_next   = ^tx.tx_data;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          line_next  = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_reg == BIT_LAST) begin
            bit_next = '0;
`ifdef SERIAL_BIT_TX_PARITY_EN
            state_next = PARITY;
            line_next  = par_reg;
`else
            state_next = STOP;
            line_next  = 1'b1;
`endif
          end else begin
            bit_next   = bit_reg + BW'(1);
            shift_next = shift_reg >> 1;
            line_next  = shift_next[0];
          end
        end
      end
`ifdef SERIAL_BIT_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_next = STOP;
          line_next  = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_next = IDLE;
          line_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        line_next  = 1'b1;
      end
    endcase
    if (state_reg != IDLE) begin
      cyc_next = bit_done ? '0 : cyc_reg + CW'(1);
    end
  end

endmodule

// File: tb/tb_serial_bit_tx.sv
// Scoreboard bench for serial_bit_tx: stimulus queues accepted words, a monitor checks each frame.
// Honours SERIAL_BIT_TX_PARITY_EN the same way as the design.
module tb_serial_bit_tx;
  localparam int W   = 8;
  localparam int CPB = 4;
`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif
  localparam int FL = NB * CPB;

  typedef struct {
    logic [W-1:0] data;
    int           cut;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic tx_line;
  logic busy;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  time  acc_time;
  time  prev_acc_time;

  serial_bit_tx_if #(.DATA_WIDTH(W)) tx_if ();

  serial_bit_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clock   (clk),
    .reset   (reset),
    .tx      (tx_if.slave),
    .tx_line (tx_line),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [W-1:0] w, input bit hold, input int cut);
    int   n;
    exp_t e;
    n = 0;
    tx_if.tx_data  = w;
    tx_if.tx_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (tx_if.tx_ready === 1'b1) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: data=%h ready never rose within 200 cycles", w);
        tx_if.tx_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    e.data = w;
    e.cut  = cut;
    exp_q.push_back(e);
    prev_acc_time = acc_time;
    acc_time      = $time;
    #1;
    if (!hold) tx_if.tx_valid = 1'b0;
  endtask

  // Monitor: idle cycles must show line high / ready; a busy cycle starts the next expected frame.
  initial begin
    exp_t       e;
    logic       bits[NB];
    int         lim;
    int         bad;
    int         first_bad;
    logic [2:0] got;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (busy !== 1'b1) begin
        checks++;
        if (tx_line !== 1'b1 || tx_if.tx_ready !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL idle: line/ready/busy=%b%b%b required 110", tx_line, tx_if.tx_ready, busy);
        end
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: busy=1 with no accepted word pending at %0t", $time);
        for (int k = 0; k < 1000 && busy === 1'b1; k++) @(negedge clk);
      end else begin
        e = exp_q.pop_front();
        bits[0] = 1'b0;
        for (int i = 0; i < W; i++) bits[i+1] = e.data[i];
`ifdef SERIAL_BIT_TX_PARITY_EN
        bits[W+1] = ^e.data;
`endif
        bits[NB-1] = 1'b1;
        lim = (e.cut > 0) ? e.cut : FL;
        bad = 0;
        first_bad = -1;
        got = 3'b000;
        for (int c = 0; c < lim; c++) begin
          if (c > 0) @(negedge clk);
          if (tx_line !== bits[c/CPB] || tx_if.tx_ready !== 1'b0 || busy !== 1'b1) begin
            if (first_bad < 0) begin
              first_bad = c;
              got = {tx_line, tx_if.tx_ready, busy};
            end
            bad++;
          end
        end
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL frame: data=%h cycle %0d line/ready/busy=%b required %b01 (%0d bad cycles)",
                   e.data, first_bad, got, bits[first_bad/CPB], bad);
        end else begin
          $display("frame data=%h cycles=%0d ok", e.data, lim);
        end
        @(negedge clk);
        checks++;
        if (tx_line !== 1'b1 || tx_if.tx_ready !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL frame_end: data=%h line/ready/busy=%b%b%b required 110",
                   e.data, tx_line, tx_if.tx_ready, busy);
        end
      end
    end
  end

  initial begin
    reset          = 1'b1;
    tx_if.tx_data  = '0;
    tx_if.tx_valid = 1'b0;
    acc_time       = 0;
    prev_acc_time  = 0;
    @(posedge clk);
    mon_en = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Single frame with a one-cycle valid pulse.
    send(8'hA5, 1'b0, 0);
    repeat (FL + 4) @(posedge clk);
    #1;

    // Valid held high: second word accepted after exactly one idle cycle.
    send(8'h3C, 1'b1, 0);
    tx_if.tx_data = 8'hFF;
    send(8'hFF, 1'b0, 0);
    checks++;
    if ((acc_time - prev_acc_time) != (FL + 1) * 10) begin
      errors++;
      $display("FAIL b2b_period: got %0d cycles required %0d", (acc_time - prev_acc_time) / 10, FL + 1);
    end else begin
      $display("b2b period=%0d cycles ok", (acc_time - prev_acc_time) / 10);
    end
    repeat (FL + 4) @(posedge clk);
    #1;

    // A valid pulse while busy must be ignored.
    send(8'hA5, 1'b0, 0);
    repeat (9) @(posedge clk);
    #1;
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_if.tx_valid = 1'b0;
    repeat (FL + 6) @(posedge clk);
    #1;

    // Reset during frame cycle 15 aborts it; the next word goes out cleanly.
    send(8'h5A, 1'b0, 15);
    repeat (14) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(8'h81, 1'b0, 0);
    repeat (FL + 4) @(posedge clk);
    #1;

    // Odd-weight word: exercises the parity bit when enabled.
    send(8'h01, 1'b0, 0);
    repeat (FL + 4) @(posedge clk);
    #1;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d expected frames never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
